// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg
//   Shared definitions for the ID/EX pipeline register slice:
//   control-bundle length and bit positions, SWAP sequencer state
//   encodings, and the helper that strips side effects from a bundle
//   whose condition check failed.
package id_ex_pipe_reg_pkg;

  localparam int CTRL_BUNDLE_LEN = 8;
  localparam int CTRL_OUT_LEN    = CTRL_BUNDLE_LEN - 1;

  // Bit positions inside ctrl_in (MSB first)
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_WB_EN      = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_STATUS_WE  = 3;
  localparam int CTRL_IMM        = 2;
  localparam int CTRL_CHOOSE_RN  = 1;
  localparam int CTRL_SWAP2      = 0;

  typedef enum logic {
    SWAP_IDLE   = 1'b0,
    SWAP_SECOND = 1'b1
  } swap_state_e;

  // Drops the swap bit and, on a failed condition, clears every bit that
  // would cause an architectural side effect. The immediate and
  // choose_rn flags only steer the datapath, so they pass through.
  // Output index is input index minus one because bit 0 is removed.
  function automatic logic [CTRL_OUT_LEN-1:0] gate_ctrl(
    input logic [CTRL_BUNDLE_LEN-1:0] ctrl,
    input logic                       cond_pass
  );
    logic [CTRL_OUT_LEN-1:0] v;
    v = ctrl[CTRL_BUNDLE_LEN-1:1];
    if (!cond_pass) begin
      v[CTRL_MEM_READ-1]  = 1'b0;
      v[CTRL_MEM_WRITE-1] = 1'b0;
      v[CTRL_WB_EN-1]     = 1'b0;
      v[CTRL_BRANCH-1]    = 1'b0;
      v[CTRL_STATUS_WE-1] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if
//   Bundles the decode-side inputs and execute-side outputs of the ID/EX
//   pipeline register.
//   master : decode/hazard side (drives *_in, freeze, flush, cond_pass)
//   slave  : the pipeline register (drives *_out, valid, swap, stop_if)
interface id_ex_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int EXEC_CMD_W = 4,
  parameter int REG_ADDR_W = 4
) ();
  import id_ex_pipe_reg_pkg::*;

  logic                       freeze;
  logic                       flush;
  logic                       cond_pass;
  logic [EXEC_CMD_W-1:0]      execute_command_in;
  logic [CTRL_BUNDLE_LEN-1:0] ctrl_in;
  logic [DATA_W-1:0]          pc_in;
  logic [DATA_W-1:0]          val_rn_in;
  logic [DATA_W-1:0]          val_rm_in;
  logic [11:0]                shift_operand_in;
  logic [23:0]                signed_imm_24_in;
  logic [REG_ADDR_W-1:0]      rn_idx_in;
  logic [REG_ADDR_W-1:0]      dest_in;
  logic [3:0]                 status_in;

  logic [EXEC_CMD_W-1:0]      execute_command_out;
  logic [CTRL_OUT_LEN-1:0]    ctrl_out;
  logic [DATA_W-1:0]          pc_out;
  logic [DATA_W-1:0]          val_rn_out;
  logic [DATA_W-1:0]          val_rm_out;
  logic [11:0]                shift_operand_out;
  logic [23:0]                signed_imm_24_out;
  logic [REG_ADDR_W-1:0]      dest_out;
  logic [3:0]                 status_out;
  logic                       valid_out;
  logic                       swap_2_state;
  logic                       stop_if;

  modport master (
    output freeze, flush, cond_pass, execute_command_in, ctrl_in, pc_in,
           val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           rn_idx_in, dest_in, status_in,
    input  execute_command_out, ctrl_out, pc_out, val_rn_out, val_rm_out,
           shift_operand_out, signed_imm_24_out, dest_out, status_out,
           valid_out, swap_2_state, stop_if
  );

  modport slave (
    input  freeze, flush, cond_pass, execute_command_in, ctrl_in, pc_in,
           val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           rn_idx_in, dest_in, status_in,
    output execute_command_out, ctrl_out, pc_out, val_rn_out, val_rm_out,
           shift_operand_out, signed_imm_24_out, dest_out, status_out,
           valid_out, swap_2_state, stop_if
  );

endinterface

// File: rtl/id_ex_pipe_reg_swap_sequencer.sv
// id_ex_pipe_reg_swap_sequencer
//   Two-state sequencer for the two-pass SWAP instruction.
//   clk, rst (async, active-low)
//   freeze, flush    : pipeline control (flush wins over freeze)
//   cond_pass        : condition result of the instruction being captured
//   swap_req         : swap_2_out bit of the instruction being captured
//   swap_2_state     : second pass pending, fed back to the control unit
//   stop_if          : hold PC and IF/ID while the second pass issues
module id_ex_pipe_reg_swap_sequencer
  import id_ex_pipe_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic flush,
  input  logic cond_pass,
  input  logic swap_req,
  output logic swap_2_state,
  output logic stop_if
);

  swap_state_e state_q;
  swap_state_e state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SWAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The second pass leaves SWAP2 on its own capture regardless of what
  // it carries, so back-to-back SWAPs can never overlap.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SWAP_IDLE;
    end else if (!freeze) begin
      case (state_q)
        SWAP_IDLE:   if (swap_req && cond_pass) state_d = SWAP_SECOND;
        SWAP_SECOND: state_d = SWAP_IDLE;
        default:     state_d = SWAP_IDLE;
      endcase
    end
  end

  // Both outputs decode straight from the state flop: no input-to-output
  // combinational path into the fetch stage.
  assign swap_2_state = (state_q == SWAP_SECOND);
  assign stop_if      = (state_q == SWAP_SECOND);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   Pipeline register between decode and execute. Captures control
//   bundle, operands and immediates each cycle, with freeze (hold) and
//   flush (squash) control, condition-fail side-effect killing, and the
//   two-pass SWAP sequencer.
//   clk, rst (async, active-low)
//   bus : id_ex_pipe_reg_if.slave carrying all decode inputs and
//         execute-side outputs
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int EXEC_CMD_W = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_pipe_reg_if.slave    bus
);

  logic [EXEC_CMD_W-1:0]   cmd_q;
  logic [CTRL_OUT_LEN-1:0] ctrl_q;
  logic [DATA_W-1:0]       pc_q;
  logic [DATA_W-1:0]       rn_q;
  logic [DATA_W-1:0]       rm_q;
  logic [11:0]             shift_q;
  logic [23:0]             imm_q;
  logic [REG_ADDR_W-1:0]   dest_q;
  logic [3:0]              status_q;
  logic                    valid_q;
  logic [REG_ADDR_W-1:0]   dest_sel;

  assign dest_sel = bus.ctrl_in[CTRL_CHOOSE_RN] ? bus.rn_idx_in : bus.dest_in;

  // On flush only the fields that can cause side effects are cleared;
  // the datapath keeps capturing since nothing downstream consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q    <= '0;
      ctrl_q   <= '0;
      pc_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      imm_q    <= '0;
      dest_q   <= '0;
      status_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus.flush || !bus.freeze) begin
      pc_q     <= bus.pc_in;
      rn_q     <= bus.val_rn_in;
      rm_q     <= bus.val_rm_in;
      shift_q  <= bus.shift_operand_in;
      imm_q    <= bus.signed_imm_24_in;
      dest_q   <= dest_sel;
      status_q <= bus.status_in;
      if (bus.flush) begin
        cmd_q   <= '0;
        ctrl_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        cmd_q   <= bus.execute_command_in;
        ctrl_q  <= gate_ctrl(bus.ctrl_in, bus.cond_pass);
        valid_q <= bus.cond_pass;
      end
    end
  end

  id_ex_pipe_reg_swap_sequencer u_swap_seq (
    .clk          (clk),
    .rst          (rst),
    .freeze       (bus.freeze),
    .flush        (bus.flush),
    .cond_pass    (bus.cond_pass),
    .swap_req     (bus.ctrl_in[CTRL_SWAP2]),
    .swap_2_state (bus.swap_2_state),
    .stop_if      (bus.stop_if)
  );

  assign bus.execute_command_out = cmd_q;
  assign bus.ctrl_out            = ctrl_q;
  assign bus.pc_out              = pc_q;
  assign bus.val_rn_out          = rn_q;
  assign bus.val_rm_out          = rm_q;
  assign bus.shift_operand_out   = shift_q;
  assign bus.signed_imm_24_out   = imm_q;
  assign bus.dest_out            = dest_q;
  assign bus.status_out          = status_q;
  assign bus.valid_out           = valid_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg
//   Table-driven bench for id_ex_pipe_reg plus hand-written sequences for
//   asynchronous reset mid-stream and SWAP abort.
module tb_id_ex_pipe_reg;

  localparam int DATA_W     = 32;
  localparam int EXEC_CMD_W = 4;
  localparam int REG_ADDR_W = 4;
  localparam int NV         = 19;

  logic clk;
  logic rst;

  id_ex_pipe_reg_if #(.DATA_W(DATA_W), .EXEC_CMD_W(EXEC_CMD_W), .REG_ADDR_W(REG_ADDR_W)) bus_if ();

  id_ex_pipe_reg #(.DATA_W(DATA_W), .EXEC_CMD_W(EXEC_CMD_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        freeze;
    logic        flush;
    logic        cond_pass;
    logic [3:0]  cmd;
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] shift;
    logic [23:0] imm;
    logic [3:0]  rn_idx;
    logic [3:0]  dest;
    logic [3:0]  status;
  } in_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [6:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] shift;
    logic [23:0] imm;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic        valid;
    logic        swap;
    logic        stop;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
    bit   chk_data;
  } vec_t;

  int   n_vectors = 0;
  int   n_miss    = 0;
  vec_t vecs[NV];
  exp_t zero_e;

  task automatic driveInputs(input in_t s);
    bus_if.freeze             = s.freeze;
    bus_if.flush              = s.flush;
    bus_if.cond_pass          = s.cond_pass;
    bus_if.execute_command_in = s.cmd;
    bus_if.ctrl_in            = s.ctrl;
    bus_if.pc_in              = s.pc;
    bus_if.val_rn_in          = s.rn;
    bus_if.val_rm_in          = s.rm;
    bus_if.shift_operand_in   = s.shift;
    bus_if.signed_imm_24_in   = s.imm;
    bus_if.rn_idx_in          = s.rn_idx;
    bus_if.dest_in            = s.dest;
    bus_if.status_in          = s.status;
  endtask

  task automatic applyStimulus(input in_t s);
    driveInputs(s);
    @(posedge clk);
    #1;
  endtask

  task automatic cmpField(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input exp_t e, input bit chk_data);
    n_vectors++;
    cmpField(idx, "execute_command_out", 32'(bus_if.execute_command_out), 32'(e.cmd));
    cmpField(idx, "ctrl_out", 32'(bus_if.ctrl_out), 32'(e.ctrl));
    cmpField(idx, "valid_out", 32'(bus_if.valid_out), 32'(e.valid));
    cmpField(idx, "swap_2_state", 32'(bus_if.swap_2_state), 32'(e.swap));
    cmpField(idx, "stop_if", 32'(bus_if.stop_if), 32'(e.stop));
    if (chk_data) begin
      cmpField(idx, "pc_out", bus_if.pc_out, e.pc);
      cmpField(idx, "val_rn_out", bus_if.val_rn_out, e.rn);
      cmpField(idx, "val_rm_out", bus_if.val_rm_out, e.rm);
      cmpField(idx, "shift_operand_out", 32'(bus_if.shift_operand_out), 32'(e.shift));
      cmpField(idx, "signed_imm_24_out", 32'(bus_if.signed_imm_24_out), 32'(e.imm));
      cmpField(idx, "dest_out", 32'(bus_if.dest_out), 32'(e.dest));
      cmpField(idx, "status_out", 32'(bus_if.status_out), 32'(e.status));
    end
  endtask

  initial begin
    in_t  s;
    exp_t e;

    zero_e = '{default: '0};

    // Plain capture, condition fail, choose_rn, wide values
    vecs[0]  = '{'{1'b0, 1'b0, 1'b1, 4'h1, 8'b0010_0000, 32'h10, 32'h100, 32'h200, 12'h0AB, 24'h000123, 4'd7, 4'd3, 4'b1010},
                 '{4'h1, 7'b0010000, 32'h10, 32'h100, 32'h200, 12'h0AB, 24'h000123, 4'd3, 4'b1010, 1'b1, 1'b0, 1'b0}, 1'b1};
    vecs[1]  = '{'{1'b0, 1'b0, 1'b0, 4'h2, 8'b1010_0000, 32'h14, 32'h111, 32'h222, 12'h0CD, 24'h000456, 4'd4, 4'd6, 4'b0101},
                 '{4'h2, 7'b0000000, 32'h14, 32'h111, 32'h222, 12'h0CD, 24'h000456, 4'd6, 4'b0101, 1'b0, 1'b0, 1'b0}, 1'b1};
    vecs[2]  = '{'{1'b0, 1'b0, 1'b1, 4'h4, 8'b0011_1110, 32'h18, 32'h333, 32'h444, 12'hFFF, 24'hFFFFFF, 4'd9, 4'd2, 4'b1111},
                 '{4'h4, 7'b0011111, 32'h18, 32'h333, 32'h444, 12'hFFF, 24'hFFFFFF, 4'd9, 4'b1111, 1'b1, 1'b0, 1'b0}, 1'b1};
    vecs[3]  = '{'{1'b0, 1'b0, 1'b0, 4'h5, 8'b1111_1110, 32'h1C, 32'hAAAA, 32'h5555, 12'h123, 24'h800000, 4'd1, 4'd8, 4'b0000},
                 '{4'h5, 7'b0000011, 32'h1C, 32'hAAAA, 32'h5555, 12'h123, 24'h800000, 4'd1, 4'b0000, 1'b0, 1'b0, 1'b0}, 1'b1};
    vecs[4]  = '{'{1'b0, 1'b0, 1'b1, 4'hF, 8'b1101_1000, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 12'h800, 24'h7FFFFF, 4'd15, 4'd14, 4'b0011},
                 '{4'hF, 7'b1101100, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 12'h800, 24'h7FFFFF, 4'd14, 4'b0011, 1'b1, 1'b0, 1'b0}, 1'b1};
    // Freeze three cycles (swap bit set must not start the sequencer)
    for (int k = 5; k < 8; k++) begin
      vecs[k] = '{'{1'b1, 1'b0, 1'b1, 4'h7, 8'b0000_0011, 32'h40 + 32'(k), 32'h1, 32'h2, 12'h3, 24'h4, 4'd2, 4'd5, 4'b0110},
                  vecs[4].e, 1'b1};
    end
    // Freeze and flush together: flush wins
    vecs[8]  = '{'{1'b1, 1'b1, 1'b1, 4'h8, 8'b1110_0001, 32'h50, 32'h1, 32'h2, 12'h3, 24'h4, 4'd2, 4'd5, 4'b0110},
                 zero_e, 1'b0};
    vecs[9]  = '{'{1'b0, 1'b0, 1'b1, 4'h3, 8'b0100_0100, 32'h20, 32'h1, 32'h2, 12'h3, 24'h4, 4'd5, 4'd6, 4'b1000},
                 '{4'h3, 7'b0100010, 32'h20, 32'h1, 32'h2, 12'h3, 24'h4, 4'd6, 4'b1000, 1'b1, 1'b0, 1'b0}, 1'b1};
    // SWAP first pass, second pass with choose_rn
    vecs[10] = '{'{1'b0, 1'b0, 1'b1, 4'h6, 8'b0010_0001, 32'h24, 32'h1234, 32'h5678, 12'h010, 24'h000010, 4'd5, 4'd2, 4'b0100},
                 '{4'h6, 7'b0010000, 32'h24, 32'h1234, 32'h5678, 12'h010, 24'h000010, 4'd2, 4'b0100, 1'b1, 1'b1, 1'b1}, 1'b1};
    vecs[11] = '{'{1'b0, 1'b0, 1'b1, 4'h6, 8'b0010_0010, 32'h24, 32'h9ABC, 32'hDEF0, 12'h010, 24'h000010, 4'd5, 4'd2, 4'b0100},
                 '{4'h6, 7'b0010001, 32'h24, 32'h9ABC, 32'hDEF0, 12'h010, 24'h000010, 4'd5, 4'b0100, 1'b1, 1'b0, 1'b0}, 1'b1};
    // Back-to-back SWAP, aborted by flush on the cycle after its first pass
    vecs[12] = '{'{1'b0, 1'b0, 1'b1, 4'h6, 8'b0010_0001, 32'h28, 32'h11, 32'h22, 12'h020, 24'h000020, 4'd7, 4'd3, 4'b0010},
                 '{4'h6, 7'b0010000, 32'h28, 32'h11, 32'h22, 12'h020, 24'h000020, 4'd3, 4'b0010, 1'b1, 1'b1, 1'b1}, 1'b1};
    vecs[13] = '{'{1'b0, 1'b1, 1'b1, 4'h6, 8'b0010_0010, 32'h28, 32'h33, 32'h44, 12'h020, 24'h000020, 4'd7, 4'd3, 4'b0010},
                 zero_e, 1'b0};
    // SWAP held by freeze in SWAP2; second pass also carrying the swap bit
    vecs[14] = '{'{1'b0, 1'b0, 1'b1, 4'h9, 8'b0010_0001, 32'h2C, 32'h55, 32'h66, 12'h030, 24'h000030, 4'd8, 4'd4, 4'b0001},
                 '{4'h9, 7'b0010000, 32'h2C, 32'h55, 32'h66, 12'h030, 24'h000030, 4'd4, 4'b0001, 1'b1, 1'b1, 1'b1}, 1'b1};
    vecs[15] = '{'{1'b1, 1'b0, 1'b1, 4'hA, 8'b0000_0010, 32'h30, 32'h77, 32'h88, 12'h040, 24'h000040, 4'd9, 4'd10, 4'b1001},
                 vecs[14].e, 1'b1};
    vecs[16] = '{'{1'b0, 1'b0, 1'b1, 4'h9, 8'b0010_0011, 32'h2C, 32'h99, 32'hAA, 12'h030, 24'h000030, 4'd8, 4'd4, 4'b0001},
                 '{4'h9, 7'b0010001, 32'h2C, 32'h99, 32'hAA, 12'h030, 24'h000030, 4'd8, 4'b0001, 1'b1, 1'b0, 1'b0}, 1'b1};
    // Failed-condition SWAP is a single pass
    vecs[17] = '{'{1'b0, 1'b0, 1'b0, 4'hB, 8'b0010_0001, 32'h30, 32'hBB, 32'hCC, 12'h050, 24'h000050, 4'd11, 4'd12, 4'b1100},
                 '{4'hB, 7'b0000000, 32'h30, 32'hBB, 32'hCC, 12'h050, 24'h000050, 4'd12, 4'b1100, 1'b0, 1'b0, 1'b0}, 1'b1};
    vecs[18] = '{'{1'b0, 1'b0, 1'b1, 4'hC, 8'b0000_0000, 32'h34, 32'hDD, 32'hEE, 12'h060, 24'h000060, 4'd13, 4'd1, 4'b0111},
                 '{4'hC, 7'b0000000, 32'h34, 32'hDD, 32'hEE, 12'h060, 24'h000060, 4'd1, 4'b0111, 1'b1, 1'b0, 1'b0}, 1'b1};

    // Power-on reset: outputs zero without any clock edge
    rst = 1'b0;
    driveInputs('{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 32'h0, 32'h0, 12'h0, 24'h0, 4'd0, 4'd0, 4'd0});
    #1;
    checkOutput(90, zero_e, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] applying %0d table vectors", NV);
    for (int k = 0; k < NV; k++) begin
      applyStimulus(vecs[k].i);
      checkOutput(k, vecs[k].e, vecs[k].chk_data);
    end

    // Reset mid-stream while a SWAP second pass is pending
    s = '{1'b0, 1'b0, 1'b1, 4'h1, 8'b0010_0001, 32'h100, 32'h5, 32'h6, 12'h007, 24'h000008, 4'd2, 4'd9, 4'b1010};
    applyStimulus(s);
    e = '{4'h1, 7'b0010000, 32'h100, 32'h5, 32'h6, 12'h007, 24'h000008, 4'd9, 4'b1010, 1'b1, 1'b1, 1'b1};
    checkOutput(200, e, 1'b1);
    #2 rst = 1'b0;
    #1 checkOutput(201, zero_e, 1'b1);
    #1 rst = 1'b1;
    // Sequencer was reset to IDLE, so this SWAP starts a fresh first pass
    s = '{1'b0, 1'b0, 1'b1, 4'h2, 8'b0010_0001, 32'h104, 32'h7, 32'h8, 12'h009, 24'h00000A, 4'd3, 4'd11, 4'b0101};
    applyStimulus(s);
    e = '{4'h2, 7'b0010000, 32'h104, 32'h7, 32'h8, 12'h009, 24'h00000A, 4'd11, 4'b0101, 1'b1, 1'b1, 1'b1};
    checkOutput(202, e, 1'b1);
    // Abort that SWAP with a flush
    s = '{1'b0, 1'b1, 1'b1, 4'h2, 8'b0010_0010, 32'h104, 32'h9, 32'hA, 12'h009, 24'h00000A, 4'd3, 4'd11, 4'b0101};
    applyStimulus(s);
    checkOutput(203, zero_e, 1'b0);
    // Next plain instruction is not treated as a second pass
    s = '{1'b0, 1'b0, 1'b1, 4'h3, 8'b0010_0000, 32'h108, 32'hB, 32'hC, 12'h00D, 24'h00000E, 4'd4, 4'd12, 4'b0001};
    applyStimulus(s);
    e = '{4'h3, 7'b0010000, 32'h108, 32'hB, 32'hC, 12'h00D, 24'h00000E, 4'd12, 4'b0001, 1'b1, 1'b0, 1'b0};
    checkOutput(204, e, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between decode (control-unit outputs, register-file reads) and execute.
- Captures the control bundle, operands and immediates each cycle; supports freeze (hazard stall) and flush (taken branch).
- Kills the instruction's side effects when its condition check fails.
- Owns the two-pass SWAP sequencer: feeds the second-pass flag back to the control unit and holds fetch/decode while the second pass is issued.

Parameters:
DATA_W, 32, width of PC and register operands
EXEC_CMD_W, 4, width of the ALU execute command
REG_ADDR_W, 4, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
freeze  in  1  hazard stall: hold all registers
flush  in  1  taken branch in EX: squash the instruction being captured
cond_pass  in  1  condition check result for the decoded instruction
execute_command_in  in  EXEC_CMD_W  ALU command from control unit
ctrl_in  in  8  {mem_read, mem_write, wb_enable, branch_taken, status_write_enable, immediate, choose_rn_as_des, swap_2_out}, MSB first
pc_in / val_rn_in / val_rm_in  in  DATA_W  PC+4, Rn value, Rm value
shift_operand_in  in  12  shifter operand field
signed_imm_24_in  in  24  branch offset
rn_idx_in / dest_in  in  REG_ADDR_W  Rn index, Rd index
status_in  in  4  NZCV at decode
execute_command_out  out  EXEC_CMD_W  registered command
ctrl_out  out  7  registered ctrl_in[7:1], same order
pc_out / val_rn_out / val_rm_out  out  DATA_W  registered operands
shift_operand_out  out  12  registered
signed_imm_24_out  out  24  registered
dest_out  out  REG_ADDR_W  selected write-back index
status_out  out  4  registered NZCV
valid_out  out  1  EX holds a live instruction
swap_2_state  out  1  to control unit swap_2_in: second SWAP pass pending
stop_if  out  1  hold PC and IF/ID register

Behaviour:
- Reset (rst=0, async): every output 0; FSM goes to IDLE.
- Latency: one cycle; inputs present at edge N appear on outputs after edge N.
- Priority at each edge: flush > freeze > capture.
- flush=1:
  - ctrl_out, execute_command_out and valid_out are cleared.
  - Datapath registers capture normally; their values are don't-care.
  - FSM forced to IDLE, aborting any SWAP in progress.
- freeze=1 (no flush): all registers and the FSM hold.
- Capture:
  - When cond_pass=0: ctrl_out bits mem_read, mem_write, wb_enable, branch_taken and status_write_enable are forced 0; valid_out=0.
  - Otherwise: ctrl_out = ctrl_in[7:1] and valid_out=1.
  - dest_out = ctrl_in[1] (choose_rn_as_des) ? rn_idx_in : dest_in.
- SWAP FSM, states IDLE and SWAP2:
  - IDLE→SWAP2 on a capture edge with swap_2_out=1 and cond_pass=1.
  - SWAP2→IDLE on the next capture edge, unconditionally.
  - swap_2_state = (state==SWAP2).
  - stop_if = (state==SWAP2), a registered output with no combinational path from inputs.
  - While in SWAP2, freeze holds the state; flush or reset returns it to IDLE.
  - A failed-condition SWAP is a single pass and stays in IDLE.
- Back-to-back SWAPs: the second SWAP is captured while in IDLE after the first completes, so there is no overlap.

Decomposition:
- Shared defines header (existing) gains: CTRL_BUNDLE_LEN=8, the ctrl bit positions, and SWAP_IDLE/SWAP_SECOND state encodings.
- One sub-module is natural: swap_sequencer, holding the 2-state FSM and producing swap_2_state and stop_if.
- The register bank stays inline.

Test Plan:
- Reset mid-stream: stream ADD with wb=1, drop rst for a partial cycle → all outputs 0 immediately; first capture after release shows the next instruction.
- Plain capture: ctrl_in=8'b0010_0000, pc_in=0x10, dest_in=3, cond_pass=1 → next cycle ctrl_out=7'b0010000, pc_out=0x10, dest_out=3, valid_out=1.
- Cond fail: LDR with ctrl_in=8'b1010_0000, cond_pass=0 → ctrl_out=0, valid_out=0, val_rn_out still updated.
- Freeze then flush: freeze=1 for 3 cycles → outputs unchanged; then freeze=1 and flush=1 together → ctrl_out=0, valid_out=0 (flush wins).
- SWAP: cycle 1 ctrl_in swap bit=1, choose_rn=0, dest_in=2 → swap_2_state=1, stop_if=1, dest_out=2. Cycle 2 choose_rn=1, rn_idx_in=5 → dest_out=5, swap_2_state=0, stop_if=0.
- SWAP abort: flush on the cycle after the first pass → swap_2_state=0, stop_if=0, valid_out=0.
